riscv_instr_aligner: RTL and testbench
======================================

Name: riscv_instr_aligner

Overview:
- Sits in the IF stage between the prefetch buffer and the compressed decoder.
- Accepts word-aligned 32-bit fetch words and emits one instruction per handshake: either a 16-bit compressed halfword or a full 32-bit instruction.
- A 32-bit instruction may straddle two fetch words; the block reassembles it.
- Also handles branch targets at halfword offset 2, and gives each instruction the correct PC.

Parameters:
ADDR_WIDTH, 32, width of fetch and instruction addresses

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
branch_i  input  1  flush request; target is branch_addr_i
branch_addr_i  input  ADDR_WIDTH  branch target, halfword aligned; bit 1 selects the start halfword
fetch_valid_i  input  1  fetch word available
fetch_rdata_i  input  32  fetch word
fetch_addr_i  input  ADDR_WIDTH  fetch word address; bits [1:0] ignored
fetch_ready_o  output  1  pop current fetch word
instr_valid_o  output  1  instruction available
instr_rdata_o  output  32  instruction; for compressed: [15:0] = halfword, [31:16] = 16'h0000
instr_addr_o  output  ADDR_WIDTH  PC of instr_rdata_o
instr_compressed_o  output  1  instr_rdata_o[1:0] != 2'b11
instr_ready_i  input  1  consumer accepts instruction

Behaviour:
- Reset (rst_n = 0, asynchronous):
  - state = IDLE; r_half = 16'h0; r_addr = 0.
  - Outputs: instr_valid_o = 0, fetch_ready_o = 0, instr_rdata_o = 0, instr_addr_o = 0, instr_compressed_o = 0.
- Classification: a halfword h is compressed iff h[1:0] != 2'b11.
- Outputs are combinational from state, the registers and the fetch inputs; latency 0.
- Handshake occurs when instr_valid_o & instr_ready_i in the same cycle.
- Once instr_valid_o rises, instr_rdata_o and instr_addr_o hold stable until the handshake, unless branch_i is asserted.
- branch_i has highest priority in every state:
  - That cycle: instr_valid_o = 0 and fetch_ready_o = 0; any concurrent fetch word is ignored.
  - Next state = branch_addr_i[1] ? BRANCH_MIS : ALIGNED.
  - Registers are left unchanged.
- IDLE:
  - valid = 0, ready = 0.
  - Left only via branch_i (the boot jump).
- ALIGNED, instruction starts at fetch word [15:0]:
  - instr_valid_o = fetch_valid_i; instr_addr_o = {fetch_addr_i[31:2], 2'b00}.
  - If the lower half is compressed:
    - Output {16'h0, rdata[15:0]}.
    - On handshake: fetch_ready_o = 1; r_half <= rdata[31:16]; r_addr <= fetch_addr + 2.
    - Next state = MIS16 if the upper half is compressed, else MIS32.
  - Else (32-bit instruction):
    - Output rdata.
    - On handshake: fetch_ready_o = 1; stay in ALIGNED.
- MIS32, r_half holds the low half of a 32-bit instruction:
  - Output {rdata[15:0], r_half}; instr_addr_o = r_addr; instr_valid_o = fetch_valid_i.
  - On handshake: pop the word; r_half <= rdata[31:16]; r_addr <= fetch_addr + 2.
  - Next state = MIS16 or MIS32, by the new upper half.
- MIS16, r_half is a complete compressed instruction:
  - instr_valid_o = 1 regardless of fetch_valid_i; fetch_ready_o = 0.
  - Output {16'h0, r_half}, addr = r_addr.
  - On handshake: go to ALIGNED.
- BRANCH_MIS, lower half of the fetch word is discarded:
  - If fetch_valid_i and upper half compressed:
    - Output {16'h0, rdata[31:16]}; addr = {fetch_addr[31:2], 2'b10}.
    - On handshake: pop, go to ALIGNED.
  - If fetch_valid_i and upper half is 32-bit:
    - instr_valid_o = 0; fetch_ready_o = 1 unconditionally.
    - r_half <= rdata[31:16]; r_addr <= {fetch_addr[31:2], 2'b10}; go to MIS32.
- Boundary cases:
  - fetch_valid_i = 0 in ALIGNED, MIS32 or BRANCH_MIS: no output, no state change.
  - instr_ready_i = 0: no pop and no state change; BRANCH_MIS with a 32-bit upper half is the only exception.
  - Address arithmetic wraps modulo 2^ADDR_WIDTH.
  - Reset mid-operation discards r_half immediately.

Decomposition:
- riscv_defines gains:
  - typedef enum logic [2:0] align_state_e: IDLE, ALIGNED, MIS16, MIS32, BRANCH_MIS.
  - Function is_compressed_half(logic [15:0]).
- No sub-module: one state register plus the r_half/r_addr registers; roughly 150–200 lines of RTL.

Test Plan:
- Reset, then branch_i to 0x80 with word 0x00A00093 (32-bit) at 0x80 -> one handshake yields rdata 0x00A00093, addr 0x80, compressed 0, fetch_ready_o pulses 1.
- Word 0x45014501 at 0x100, ready = 1 -> cycle 1: {0, 0x4501} at 0x100, pop; cycle 2 (MIS16): {0, 0x4501} at 0x102, no pop.
- Words 0x00934501 at 0x200 and 0x450100A0 at 0x204 -> 0x4501 at 0x200; then 0x00A00093 at 0x202; then 0x4501 at 0x206.
- branch_i to 0x302 with 0x00934501 at 0x300 -> BRANCH_MIS pops with valid 0; then with 0xXXXX00A0 at 0x304 -> 0x00A00093 at 0x302.
- instr_ready_i held 0 for 5 cycles in MIS32 -> outputs stable, no pops; branch_i asserted mid-stall -> valid 0 that cycle, r_half dropped, new target fetched.
- rst_n deasserted-asserted in MIS16 -> next cycle state IDLE, valid 0, ready 0 even with fetch_valid_i = 1.

Source files
------------

// File: rtl/riscv_defines.sv
// Shared types and helpers for the instruction fetch stage.
package riscv_defines;

  typedef enum logic [2:0] {
    IDLE,
    ALIGNED,
    MIS16,
    MIS32,
    BRANCH_MIS
  } align_state_e;

  function automatic logic is_compressed_half(input logic [15:0] h);
    return h[1:0] != 2'b11;
  endfunction

endpackage

// File: rtl/riscv_instr_aligner.sv
// Instruction aligner: turns word-aligned fetch words into a stream of
// 16-bit compressed or 32-bit instructions, reassembling straddling ones.
module riscv_instr_aligner
  import riscv_defines::*;
#(
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  branch_i,
  input  logic [ADDR_WIDTH-1:0] branch_addr_i,
  input  logic                  fetch_valid_i,
  input  logic [31:0]           fetch_rdata_i,
  input  logic [ADDR_WIDTH-1:0] fetch_addr_i,
  output logic                  fetch_ready_o,
  output logic                  instr_valid_o,
  output logic [31:0]           instr_rdata_o,
  output logic [ADDR_WIDTH-1:0] instr_addr_o,
  output logic                  instr_compressed_o,
  input  logic                  instr_ready_i
);

  align_state_e          r_state;
  align_state_e          w_next_state;
  logic [15:0]           r_half;
  logic [ADDR_WIDTH-1:0] r_addr;

  logic [15:0]           w_lo;
  logic [15:0]           w_hi;
  logic [ADDR_WIDTH-1:0] w_word_addr;
  logic [ADDR_WIDTH-1:0] w_upper_addr;
  logic                  w_valid;
  logic                  w_ready;
  logic [31:0]           w_rdata;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic                  w_hs;
  logic                  w_load;
  logic                  w_unused_addr_bits;

  assign w_lo         = fetch_rdata_i[15:0];
  assign w_hi         = fetch_rdata_i[31:16];
  assign w_word_addr  = {fetch_addr_i[ADDR_WIDTH-1:2], 2'b00};
  assign w_upper_addr = w_word_addr + ADDR_WIDTH'(2);
  assign w_hs         = w_valid & instr_ready_i;

  // Only bit 1 of the branch target matters here; the fetch unit uses the rest.
  assign w_unused_addr_bits = ^{branch_addr_i[ADDR_WIDTH-1:2], branch_addr_i[0],
                                fetch_addr_i[1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    if (branch_i) begin
      w_next_state = branch_addr_i[1] ? BRANCH_MIS : ALIGNED;
    end else begin
      case (r_state)
        ALIGNED: begin
          if (w_hs && is_compressed_half(w_lo)) begin
            w_next_state = is_compressed_half(w_hi) ? MIS16 : MIS32;
          end
        end
        MIS32: begin
          if (w_hs) begin
            w_next_state = is_compressed_half(w_hi) ? MIS16 : MIS32;
          end
        end
        MIS16: begin
          if (w_hs) begin
            w_next_state = ALIGNED;
          end
        end
        BRANCH_MIS: begin
          if (fetch_valid_i) begin
            if (!is_compressed_half(w_hi)) begin
              w_next_state = MIS32;
            end else if (w_hs) begin
              w_next_state = ALIGNED;
            end
          end
        end
        default: w_next_state = r_state;
      endcase
    end
  end

  always_comb begin
    w_valid = 1'b0;
    w_ready = 1'b0;
    w_rdata = '0;
    w_addr  = '0;
    case (r_state)
      ALIGNED: begin
        w_valid = fetch_valid_i;
        w_addr  = w_word_addr;
        w_rdata = is_compressed_half(w_lo) ? {16'h0000, w_lo} : fetch_rdata_i;
        w_ready = w_valid & instr_ready_i;
      end
      MIS32: begin
        w_valid = fetch_valid_i;
        w_addr  = r_addr;
        w_rdata = {w_lo, r_half};
        w_ready = w_valid & instr_ready_i;
      end
      MIS16: begin
        w_valid = 1'b1;
        w_addr  = r_addr;
        w_rdata = {16'h0000, r_half};
      end
      BRANCH_MIS: begin
        w_addr  = w_upper_addr;
        w_rdata = {16'h0000, w_hi};
        // A 32-bit upper half is banked without presenting anything.
        if (is_compressed_half(w_hi)) begin
          w_valid = fetch_valid_i;
          w_ready = w_valid & instr_ready_i;
        end else begin
          w_ready = fetch_valid_i;
        end
      end
      default: ;
    endcase
    if (branch_i) begin
      w_valid = 1'b0;
      w_ready = 1'b0;
    end
  end

  // Any pop that leaves a half pending banks the upper half and its PC.
  assign w_load = w_ready && (w_next_state == MIS16 || w_next_state == MIS32);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_half <= '0;
      r_addr <= '0;
    end else if (w_load) begin
      r_half <= w_hi;
      r_addr <= w_upper_addr;
    end
  end

  assign fetch_ready_o      = w_ready;
  assign instr_valid_o      = w_valid;
  assign instr_rdata_o      = w_rdata;
  assign instr_addr_o       = w_addr;
  assign instr_compressed_o = (r_state != IDLE) && is_compressed_half(w_rdata[15:0]);

endmodule

// File: tb/tb_riscv_instr_aligner.sv
// Randomized scoreboard bench: a halfword-stream program model predicts the
// instruction sequence after each branch; a monitor checks every handshake.
module tb_riscv_instr_aligner;

  localparam int unsigned AW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          branch_i;
  logic [AW-1:0] branch_addr_i;
  logic          fetch_valid_i;
  logic [31:0]   fetch_rdata_i;
  logic [AW-1:0] fetch_addr_i;
  logic          fetch_ready_o;
  logic          instr_valid_o;
  logic [31:0]   instr_rdata_o;
  logic [AW-1:0] instr_addr_o;
  logic          instr_compressed_o;
  logic          instr_ready_i;

  always #5 clk = ~clk;

  riscv_instr_aligner #(.ADDR_WIDTH(AW)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .branch_i          (branch_i),
    .branch_addr_i     (branch_addr_i),
    .fetch_valid_i     (fetch_valid_i),
    .fetch_rdata_i     (fetch_rdata_i),
    .fetch_addr_i      (fetch_addr_i),
    .fetch_ready_o     (fetch_ready_o),
    .instr_valid_o     (instr_valid_o),
    .instr_rdata_o     (instr_rdata_o),
    .instr_addr_o      (instr_addr_o),
    .instr_compressed_o(instr_compressed_o),
    .instr_ready_i     (instr_ready_i)
  );

  typedef struct {
    logic [31:0] d;
    logic [31:0] a;
    logic        c;
  } exp_t;

  logic [15:0] mem [256];
  exp_t        sbq[$];
  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  // Program image repeats every 512 bytes, so addresses wrap consistently.
  function automatic logic [15:0] mh(input logic [31:0] a);
    return mem[a[8:1]];
  endfunction

  function automatic logic [31:0] fword(input logic [31:0] a);
    return {mh(a + 32'd2), mh(a)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valid"}, {31'b0, instr_valid_o}, 32'd0);
    check({tag, "_ready"}, {31'b0, fetch_ready_o}, 32'd0);
    check({tag, "_rdata"}, instr_rdata_o, 32'd0);
    check({tag, "_addr"}, instr_addr_o, 32'd0);
    check({tag, "_compressed"}, {31'b0, instr_compressed_o}, 32'd0);
  endtask

  // Walk the program from the target: each halfword either is an instruction
  // or, with the next halfword, forms a 32-bit one.
  task automatic push_stream(input logic [31:0] target, input int n);
    logic [31:0] pc;
    logic [15:0] h;
    exp_t        e;
    pc = target;
    for (int i = 0; i < n; i++) begin
      h   = mh(pc);
      e.a = pc;
      if (h[1:0] != 2'b11) begin
        e.d = {16'h0000, h};
        e.c = 1'b1;
        pc  = pc + 32'd2;
      end else begin
        e.d = {mh(pc + 32'd2), h};
        e.c = 1'b0;
        pc  = pc + 32'd4;
      end
      sbq.push_back(e);
    end
  endtask

  // Monitor
  logic        m_prev_stall = 1'b0;
  logic [31:0] m_prev_d, m_prev_a;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        m_prev_stall = 1'b0;
      end else if (branch_i) begin
        check("branch_valid", {31'b0, instr_valid_o}, 32'd0);
        check("branch_ready", {31'b0, fetch_ready_o}, 32'd0);
        m_prev_stall = 1'b0;
      end else begin
        if (m_prev_stall) begin
          check("stall_valid", {31'b0, instr_valid_o}, 32'd1);
          check("stall_rdata", instr_rdata_o, m_prev_d);
          check("stall_addr", instr_addr_o, m_prev_a);
        end
        if (instr_valid_o && instr_ready_i) begin
          if (sbq.size() == 0) begin
            check("spurious_instr", {31'b0, instr_valid_o}, 32'd0);
          end else begin
            e = sbq.pop_front();
            check("rdata", instr_rdata_o, e.d);
            check("addr", instr_addr_o, e.a);
            check("compressed", {31'b0, instr_compressed_o}, {31'b0, e.c});
          end
        end
        m_prev_stall = instr_valid_o && !instr_ready_i;
        m_prev_d     = instr_rdata_o;
        m_prev_a     = instr_addr_o;
      end
    end
  end

  // Driver: prefetch-buffer source plus random consumer back-pressure
  initial begin
    logic [31:0] fa;
    logic [31:0] target;
    logic [31:0] r;
    logic [15:0] h;
    logic        hold;
    logic        did_reset;
    int          episodes;

    for (int i = 0; i < 256; i++) begin
      h = 16'($urandom);
      if ($urandom_range(0, 1) == 1) h[1:0] = 2'b11;
      mem[i] = h;
    end

    rst_n         = 1'b0;
    branch_i      = 1'b0;
    branch_addr_i = '0;
    fetch_valid_i = 1'b1;
    fetch_rdata_i = 32'h00A00093;
    fetch_addr_i  = 32'h80;
    instr_ready_i = 1'b1;
    fa            = '0;
    hold          = 1'b0;
    did_reset     = 1'b0;
    episodes      = 0;

    repeat (2) @(negedge clk);
    #2 check_idle("reset");
    @(negedge clk);
    rst_n = 1'b1;
    #2 check_idle("idle");
    @(negedge clk);
    #2 check_idle("idle2");

    for (int cyc = 0; cyc < 30000; cyc++) begin
      @(negedge clk);
      if (sbq.size() == 0 && episodes >= 80) break;

      if (episodes >= 40 && !did_reset && sbq.size() > 2) begin
        did_reset     = 1'b1;
        rst_n         = 1'b0;
        branch_i      = 1'b0;
        fetch_valid_i = 1'b1;
        instr_ready_i = 1'b1;
        sbq.delete();
        hold = 1'b0;
        #2 check_idle("midrun_reset");
        @(negedge clk);
        rst_n = 1'b1;
        #2 check_idle("after_reset");
      end else if (sbq.size() == 0 || $urandom_range(0, 49) == 0) begin
        r = $urandom;
        if ($urandom_range(0, 7) == 0) target = 32'hFFFF_FFF0 | (r & 32'hE);
        else                           target = r & ~32'h1;
        branch_i      = 1'b1;
        branch_addr_i = target;
        fetch_valid_i = $urandom_range(0, 1) == 1;
        fetch_rdata_i = $urandom;
        fetch_addr_i  = $urandom & ~32'h3;
        instr_ready_i = 1'b1;
        sbq.delete();
        push_stream(target, int'($urandom_range(4, 16)));
        fa   = target & ~32'h3;
        hold = 1'b0;
        episodes++;
        #2;
      end else begin
        branch_i      = 1'b0;
        fetch_valid_i = hold ? 1'b1 : ($urandom_range(0, 3) != 0);
        fetch_addr_i  = fa;
        fetch_rdata_i = fword(fa);
        instr_ready_i = $urandom_range(0, 2) != 0;
        #2;
        hold = fetch_valid_i && !fetch_ready_o;
        if (fetch_valid_i && fetch_ready_o) fa = fa + 32'd4;
      end
    end

    if (sbq.size() != 0 || episodes < 80) begin
      vectors++;
      miscompares++;
      $display("FAIL timeout: %0d instructions pending after %0d episodes, expected 0 pending",
               sbq.size(), episodes);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
